// File: rtl/bbc_mem_pkg.sv
// Shared definitions for the BBC ROM/RAM block: arbiter FSM states and
// the default ROM download window.
package bbc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int unsigned ROM_WORDS = 229376;
  localparam logic [7:0]  ROM_INDEX = 8'd0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO for buffered download writes. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             one_left,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign one_left = (count == (PTR_W+1)'(1));
  assign head     = mem[rd_ptr];

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers and
  // count alone, so resetting the array would only cost routing.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares the single-port ROM/RAM between the core bus (fixed-slot priority)
// and buffered HPS ROM downloads, holding the core in reset around a load.
module bram_port_arbiter #(
  parameter int              ADDR_W         = 18,
  parameter int              DATA_W         = 8,
  parameter int unsigned     ROM_WORDS      = bbc_mem_pkg::ROM_WORDS,
  parameter logic [7:0]      ROM_INDEX      = bbc_mem_pkg::ROM_INDEX,
  parameter int              FIFO_DEPTH     = 4,
  parameter int              RELEASE_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              core_ce,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_we_n,
  input  logic [DATA_W-1:0] core_din,
  output logic [DATA_W-1:0] core_dout,
  output logic              core_hold,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              load_busy,
  output logic              ovf_err,
  output logic [7:0]        drop_cnt
);

  import bbc_mem_pkg::*;

  localparam int FIFO_W = ADDR_W + DATA_W;
  localparam int CNT_W  = $clog2(RELEASE_CYCLES + 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [CNT_W-1:0]  rel_cnt;
  logic [CNT_W-1:0]  rel_cnt_next;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_one_left;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_head;

  logic              we_q;
  logic              we_edge;
  logic              ce_q;
  logic [DATA_W-1:0] dout_hold;

  logic              rom_hit;
  logic              lost;
  logic              drop;
  logic              drain_done;

  // Download push filter: only in-window bytes for this memory are buffered.
  assign rom_hit   = ioctl_wr && (ioctl_index == ROM_INDEX) &&
                     (ioctl_addr < 25'(ROM_WORDS));
  assign fifo_pop  = !core_ce && !fifo_empty;
  assign fifo_push = rom_hit && (!fifo_full || fifo_pop);
  assign lost      = rom_hit && fifo_full && !fifo_pop;
  assign drop      = ioctl_wr && !fifo_push;
  assign fifo_din  = {ioctl_addr[ADDR_W-1:0], ioctl_dout};

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (fifo_din),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left),
    .head     (fifo_head)
  );

  // One write per falling strobe edge, and none while the core is held.
  assign we_edge = we_q && !core_we_n && !core_hold;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves a value unassigned and infers a latch.
  always_comb begin
    mem_addr = core_addr;
    mem_data = core_din;
    mem_wren = 1'b0;
    if (core_ce) begin
      mem_wren = we_edge;
    end else if (!fifo_empty) begin
      {mem_addr, mem_data} = fifo_head;
      mem_wren             = 1'b1;
    end
  end

  assign core_dout = ce_q ? mem_q : dout_hold;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b1;
      ce_q      <= 1'b0;
      dout_hold <= '0;
    end else begin
      we_q <= core_we_n;
      ce_q <= core_ce;
      if (ce_q) dout_hold <= mem_q;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (lost) ovf_err <= 1'b1;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // The drain is complete once the FIFO is, or is about to become, empty.
  assign drain_done = fifo_empty ? !fifo_push
                                 : (fifo_one_left && fifo_pop && !fifo_push);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= RELEASE;
      rel_cnt <= CNT_W'(RELEASE_CYCLES - 1);
    end else begin
      state   <= state_next;
      rel_cnt <= rel_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    rel_cnt_next = rel_cnt;
    if (ioctl_download) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        LOAD: state_next = DRAIN;
        DRAIN: begin
          if (drain_done) begin
            state_next   = RELEASE;
            rel_cnt_next = CNT_W'(RELEASE_CYCLES - 1);
          end
        end
        RELEASE: begin
          if (rel_cnt == '0) state_next = IDLE;
          else               rel_cnt_next = rel_cnt - 1'b1;
        end
        default: state_next = RELEASE;
      endcase
    end
  end

  always_comb begin
    core_hold = (state != IDLE);
    load_busy = core_hold || !fifo_empty;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 1-cycle-latency spram model.
module tb_bram_port_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic              core_ce;
  logic [ADDR_W-1:0] core_addr;
  logic              core_we_n;
  logic [DATA_W-1:0] core_din;
  logic [DATA_W-1:0] core_dout;
  logic              core_hold;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [DATA_W-1:0] ioctl_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q = '0;
  logic              load_busy;
  logic              ovf_err;
  logic [7:0]        drop_cnt;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  bram_port_arbiter dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .core_ce        (core_ce),
    .core_addr      (core_addr),
    .core_we_n      (core_we_n),
    .core_din       (core_din),
    .core_dout      (core_dout),
    .core_hold      (core_hold),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .load_busy      (load_busy),
    .ovf_err        (ovf_err),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Single-port RAM, read-before-write, one cycle of read latency.
  always @(posedge clk_sys) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    core_ce        = 1'b0;
    core_addr      = '0;
    core_we_n      = 1'b1;
    core_din       = '0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_sys);
      if (!core_hold) break;
      n++;
      next_cycle();
    end
    n_checks++;
    if (n >= 64) begin
      n_fail++;
      $display("FAIL idle_timeout: core_hold still %0b after %0d cycles, required 0", core_hold, n);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    int n;
    int busy_bad;
    next_cycle();
    @(negedge clk_sys);
    n_checks++;
    if ({core_hold, load_busy, mem_wren, ovf_err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_flags: hold/busy/wren/ovf=%b required 1100", {core_hold, load_busy, mem_wren, ovf_err});
    end
    n_checks++;
    if (core_dout !== 8'h00 || drop_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: core_dout=%0h drop_cnt=%0d required 0 0", core_dout, drop_cnt);
    end
    next_cycle();
    reset    = 1'b0;
    n        = 0;
    busy_bad = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_sys);
      if (load_busy !== core_hold) busy_bad++;
      if (!core_hold) break;
      n++;
      next_cycle();
    end
    n_checks++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL reset_hold_len: core_hold high %0d cycles, required 16", n);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL reset_busy_track: load_busy differed from core_hold in %0d cycles, required 0", busy_bad);
    end
    next_cycle();
  endtask

  task automatic test_download();
    int last_pop;
    int fall;
    int pops;
    logic [25:0] exp_w;
    last_pop = -1;
    fall     = -1;
    pops     = 0;
    for (int i = 0; i < 40; i++) begin
      core_ce        = (i % 3 == 0);
      core_addr      = 18'h1000;
      core_we_n      = 1'b1;
      ioctl_download = (i < 5);
      ioctl_index    = 8'd0;
      ioctl_wr       = (i >= 1 && i <= 4);
      ioctl_addr     = 25'(i - 1);
      ioctl_dout     = 8'(8'hA0 + i - 1);
      @(negedge clk_sys);
      if (mem_wren) begin
        n_checks++;
        if (core_ce !== 1'b0) begin
          n_fail++;
          $display("FAIL dl_slot: FIFO write in cycle %0d with core_ce=%0b, required 0", i, core_ce);
        end
        exp_w = {18'(pops), 8'(8'hA0 + pops)};
        n_checks++;
        if ({mem_addr, mem_data} !== exp_w) begin
          n_fail++;
          $display("FAIL dl_order: write %0d addr/data=%0h/%0h required %0h/%0h", pops, mem_addr, mem_data, exp_w[25:8], exp_w[7:0]);
        end
        pops++;
        last_pop = i;
      end
      if (fall < 0 && i > 0 && !core_hold) fall = i;
      next_cycle();
    end
    n_checks++;
    if (pops != 4) begin
      n_fail++;
      $display("FAIL dl_count: %0d FIFO writes, required 4", pops);
    end
    n_checks++;
    if (fall - last_pop - 1 != 16) begin
      n_fail++;
      $display("FAIL dl_release: core_hold high %0d cycles after last pop, required 16", fall - last_pop - 1);
    end
    n_checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hA0A1A2A3) begin
      n_fail++;
      $display("FAIL dl_contents: mem[0..3]=%0h required a0a1a2a3", {mem[0], mem[1], mem[2], mem[3]});
    end
  endtask

  task automatic test_overflow();
    logic [25:0] exp_q [5];
    int pops;
    int held_wren;
    exp_q[0] = {18'h10, 8'hB0};
    exp_q[1] = {18'h11, 8'hB1};
    exp_q[2] = {18'h12, 8'hB2};
    exp_q[3] = {18'h13, 8'hB3};
    exp_q[4] = {18'h18, 8'hB8};
    pops      = 0;
    held_wren = 0;
    for (int i = 0; i < 20; i++) begin
      ioctl_download = (i <= 8);
      ioctl_wr       = (i <= 8);
      ioctl_addr     = (i < 8) ? 25'(16 + i) : 25'h18;
      ioctl_dout     = (i < 8) ? 8'(8'hB0 + i) : 8'hB8;
      core_ce        = (i < 8);
      core_we_n      = (i < 8) ? ~i[0] : 1'b1;
      core_addr      = 18'h300;
      core_din       = 8'hEE;
      @(negedge clk_sys);
      if (i < 8) begin
        if (mem_wren) held_wren++;
      end else if (mem_wren) begin
        if (pops < 5) begin
          n_checks++;
          if ({mem_addr, mem_data} !== exp_q[pops]) begin
            n_fail++;
            $display("FAIL ovf_order: write %0d addr/data=%0h/%0h required %0h/%0h", pops, mem_addr, mem_data, exp_q[pops][25:8], exp_q[pops][7:0]);
          end
        end
        pops++;
      end
      next_cycle();
    end
    n_checks++;
    if (held_wren != 0) begin
      n_fail++;
      $display("FAIL ovf_held_write: %0d writes during held core slots, required 0", held_wren);
    end
    n_checks++;
    if (pops != 5) begin
      n_fail++;
      $display("FAIL ovf_count: %0d FIFO writes, required 5", pops);
    end
    n_checks++;
    if (drop_cnt !== 8'd4 || ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_stats: drop_cnt=%0d ovf_err=%0b required 4 1", drop_cnt, ovf_err);
    end
    idle_inputs();
    wait_idle();
  endtask

  task automatic test_filter();
    int bad_wren;
    pulse_reset();
    wait_idle();
    bad_wren = 0;
    for (int i = 0; i < 6; i++) begin
      ioctl_download = 1'b1;
      ioctl_wr       = (i == 0 || i == 1 || i == 3);
      ioctl_index    = (i == 0) ? 8'd1 : 8'd0;
      ioctl_addr     = (i == 0) ? 25'd5 : (i == 1) ? 25'd229376 : 25'd229375;
      ioctl_dout     = 8'h5C;
      @(negedge clk_sys);
      if (i <= 3 && mem_wren) bad_wren++;
      if (i == 4) begin
        n_checks++;
        if ({mem_wren, mem_addr, mem_data} !== {1'b1, 18'h37FFF, 8'h5C}) begin
          n_fail++;
          $display("FAIL filt_last_word: wren/addr/data=%0b/%0h/%0h required 1/37fff/5c", mem_wren, mem_addr, mem_data);
        end
      end
      next_cycle();
    end
    n_checks++;
    if (bad_wren != 0) begin
      n_fail++;
      $display("FAIL filt_no_write: %0d writes from filtered bytes, required 0", bad_wren);
    end
    n_checks++;
    if (drop_cnt !== 8'd2 || ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL filt_stats: drop_cnt=%0d ovf_err=%0b required 2 0", drop_cnt, ovf_err);
    end
    for (int i = 0; i < 260; i++) begin
      ioctl_wr    = 1'b1;
      ioctl_index = 8'd1;
      next_cycle();
    end
    ioctl_wr = 1'b0;
    next_cycle();
    n_checks++;
    if (drop_cnt !== 8'd255 || ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL filt_saturate: drop_cnt=%0d ovf_err=%0b required 255 0", drop_cnt, ovf_err);
    end
    idle_inputs();
    wait_idle();
  endtask

  task automatic test_core_write();
    int wr_cnt;
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      core_ce   = (i <= 4) ? (i % 2 == 0) : (i == 6);
      core_we_n = (i <= 4) ? 1'b0 : 1'b1;
      core_addr = (i <= 6) ? 18'h100 : 18'h200;
      core_din  = 8'h3C;
      @(negedge clk_sys);
      if (i <= 5 && mem_wren) wr_cnt++;
      if (i == 0) begin
        n_checks++;
        if ({mem_wren, mem_addr, mem_data} !== {1'b1, 18'h100, 8'h3C}) begin
          n_fail++;
          $display("FAIL cw_first_edge: wren/addr/data=%0b/%0h/%0h required 1/100/3c", mem_wren, mem_addr, mem_data);
        end
      end
      if (i >= 7) begin
        n_checks++;
        if (core_dout !== 8'h3C) begin
          n_fail++;
          $display("FAIL cw_read_hold: cycle %0d core_dout=%0h required 3c", i, core_dout);
        end
      end
      next_cycle();
    end
    n_checks++;
    if (wr_cnt != 1) begin
      n_fail++;
      $display("FAIL cw_one_write: %0d writes for one strobe, required 1", wr_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_reset_drain();
    int n;
    int wren;
    for (int i = 0; i < 9; i++) begin
      core_ce        = 1'b1;
      core_we_n      = 1'b1;
      ioctl_download = (i <= 3);
      ioctl_wr       = (i >= 1 && i <= 3);
      ioctl_addr     = 25'(64 + i);
      ioctl_dout     = 8'(8'hC0 + i);
      reset          = (i == 8);
      @(negedge clk_sys);
      if (i == 7) begin
        n_checks++;
        if (load_busy !== 1'b1 || mem_wren !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_buffered: load_busy=%0b mem_wren=%0b required 1 0", load_busy, mem_wren);
        end
      end
      next_cycle();
    end
    reset = 1'b0;
    idle_inputs();
    n    = 0;
    wren = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_sys);
      if (mem_wren) wren++;
      if (!core_hold) break;
      n++;
      next_cycle();
    end
    n_checks++;
    if (wren != 0) begin
      n_fail++;
      $display("FAIL rd_discard: %0d writes after reset, required 0", wren);
    end
    n_checks++;
    if (n != 16 || load_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_release: core_hold high %0d cycles, load_busy=%0b, required 16 0", n, load_busy);
    end
    next_cycle();
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
    idle_inputs();
    test_reset();
    test_download();
    test_overflow();
    test_filter();
    test_core_write();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
